ps2_kbd_ctrl: RTL and testbench

Scan-code sequencer that drains the PS/2 receiver FIFO and turns raw set-2 bytes into complete key events. Sits between the PS/2 receiver (consuming its `data`/`ready`/`nextdata_n` pop interface) and the keyboard consumer (CPU MMIO register or display logic). It strips `E0`/`F0` prefixes, collapses the 8-byte Pause sequence, drops line-error bytes and can filter typematic repeats.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_kbd_ctrl.sv | 147 ++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard path.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_GAP,
        ST_DECODE,
        ST_PAUSE_SKIP,
        ST_EMIT
    } kbd_ctrl_state_t;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_AA    = 8'hAA;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERRF  = 8'hFF;
    localparam logic [7:0] SC_PAUSE = 8'h77;

    localparam logic [2:0] PAUSE_TAIL = 3'd7;

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// Drains the PS/2 receiver FIFO and assembles set-2 bytes into key events.
//
// state      | meaning
// IDLE       | wait for a byte in the receiver FIFO, latch it
// ACK        | pop strobe to the receiver (kbd_nextdata_n low)
// GAP        | let the receiver ready/head settle after the pop
// DECODE     | interpret latched byte: prefix, error, self-test or key
// PAUSE_SKIP | swallow the tail of the Pause sequence
// EMIT       | hold event until the consumer accepts it
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter bit FILTER_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] err_count,
    output logic       ovf_seen
);

    kbd_ctrl_state_t state_q, state_d;

    logic [7:0] byte_q;
    logic       ext_q, brk_q;
    logic [2:0] skip_cnt;
    logic       held_v;
    logic [8:0] held_key;
    logic [7:0] code_q;
    logic       evx_q, evb_q;
    logic       ndn_q;
    logic       ovf_q;
    logic [7:0] err_q;
    logic       drop_repeat;

    // A make of the key already held is typematic repeat.
    assign drop_repeat = FILTER_REPEAT && !brk_q && held_v && (held_key == {byte_q, ext_q});

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (kbd_ready) state_d = ST_ACK;
            ST_ACK:        state_d = ST_GAP;
            ST_GAP:        state_d = (skip_cnt != 3'd0) ? ST_PAUSE_SKIP : ST_DECODE;
            ST_PAUSE_SKIP: state_d = (skip_cnt == 3'd1) ? ST_EMIT : ST_IDLE;
            ST_DECODE: begin
                case (byte_q)
                    SC_E0, SC_F0, SC_E1, SC_ERR0, SC_ERRF, SC_AA: state_d = ST_IDLE;
                    default: state_d = drop_repeat ? ST_IDLE : ST_EMIT;
                endcase
            end
            ST_EMIT:       if (ev_ready) state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q   <= 8'h00;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            skip_cnt <= 3'd0;
            held_v   <= 1'b0;
            held_key <= 9'h000;
            code_q   <= 8'h00;
            evx_q    <= 1'b0;
            evb_q    <= 1'b0;
            ndn_q    <= 1'b1;
            ovf_q    <= 1'b0;
            err_q    <= 8'h00;
        end else begin
            ndn_q <= (state_d != ST_ACK);
            ovf_q <= ovf_q | kbd_overflow;
            case (state_q)
                ST_IDLE: if (kbd_ready) byte_q <= kbd_data;
                ST_PAUSE_SKIP: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        code_q <= SC_PAUSE;
                        evx_q  <= 1'b1;
                        evb_q  <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    case (byte_q)
                        SC_E0: ext_q <= 1'b1;
                        SC_F0: brk_q <= 1'b1;
                        SC_E1: begin
                            skip_cnt <= PAUSE_TAIL;
                            ext_q    <= 1'b0;
                            brk_q    <= 1'b0;
                        end
                        SC_ERR0, SC_ERRF: begin
                            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                        SC_AA: begin
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                        default: begin
                            code_q <= byte_q;
                            evx_q  <= ext_q;
                            evb_q  <= brk_q;
                            ext_q  <= 1'b0;
                            brk_q  <= 1'b0;
                        end
                    endcase
                end
                ST_EMIT: begin
                    if (ev_ready) begin
                        if (!evb_q) begin
                            held_key <= {code_q, evx_q};
                            held_v   <= 1'b1;
                        end else if (held_key == {code_q, evx_q}) begin
                            held_v <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign kbd_nextdata_n = ndn_q;
    assign ev_valid       = (state_q == ST_EMIT);
    assign ev_code        = code_q;
    assign ev_ext         = evx_q;
    assign ev_break       = evb_q;
    assign err_count      = err_q;
    assign ovf_seen       = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench: modelled receiver FIFOs feed two controllers (repeat filter on/off).
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       kbd_overflow = 1'b0;

    logic [7:0] kbd_data = 8'h00, kbd_data1 = 8'h00;
    logic       kbd_ready = 1'b0, kbd_ready1 = 1'b0;
    logic       nd_n, nd_n1;
    logic       ev_valid, ev_valid1;
    logic       ev_ready = 1'b1, ev_ready1 = 1'b1;
    logic [7:0] ev_code, ev_code1;
    logic       ev_ext, ev_ext1, ev_break, ev_break1;
    logic [7:0] err_count, err_count1;
    logic       ovf_seen, ovf_seen1;

    logic [7:0] fifo0[$], fifo1[$];
    logic [9:0] exp0[$], exp1[$];

    int n_chk = 0, n_err = 0;
    int pops0 = 0, ev_cnt0 = 0, ev_cnt1 = 0;
    logic prev_low = 1'b0, dbl_low = 1'b0;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(.FILTER_REPEAT(1'b1)) u_dut (
        .clk(clk), .reset(reset), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(nd_n), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
        .err_count(err_count), .ovf_seen(ovf_seen)
    );

    ps2_kbd_ctrl #(.FILTER_REPEAT(1'b0)) u_dut_nf (
        .clk(clk), .reset(reset), .kbd_data(kbd_data1), .kbd_ready(kbd_ready1),
        .kbd_overflow(kbd_overflow), .kbd_nextdata_n(nd_n1), .ev_valid(ev_valid1),
        .ev_ready(ev_ready1), .ev_code(ev_code1), .ev_ext(ev_ext1), .ev_break(ev_break1),
        .err_count(err_count1), .ovf_seen(ovf_seen1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Receiver model: pop on the edge that sees the strobe low.
    always @(posedge clk) begin
        if (!nd_n) begin
            pops0++;
            if (prev_low) dbl_low = 1'b1;
            if (fifo0.size() != 0) fifo0.delete(0);
        end
        prev_low = !nd_n;
        if (!nd_n1 && fifo1.size() != 0) fifo1.delete(0);
    end

    always @(negedge clk) begin
        kbd_ready  = (fifo0.size() != 0);
        kbd_ready1 = (fifo1.size() != 0);
        if (fifo0.size() != 0) kbd_data = fifo0[0];
        else                   kbd_data = 8'h00;
        if (fifo1.size() != 0) kbd_data1 = fifo1[0];
        else                   kbd_data1 = 8'h00;
    end

    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            ev_cnt0++;
            if (exp0.size() == 0) check("ev0_extra", {ev_code, ev_ext, ev_break}, 32'h3FF);
            else                  check("ev0", {ev_code, ev_ext, ev_break}, exp0.pop_front());
        end
        if (!reset && ev_valid1 && ev_ready1) begin
            ev_cnt1++;
            if (exp1.size() == 0) check("ev1_extra", {ev_code1, ev_ext1, ev_break1}, 32'h3FF);
            else                  check("ev1", {ev_code1, ev_ext1, ev_break1}, exp1.pop_front());
        end
    end

    task automatic check_reset_outs(input string tag);
        check({tag, "_ndn"},   nd_n, 1);
        check({tag, "_valid"}, ev_valid, 0);
        check({tag, "_code"},  ev_code, 0);
        check({tag, "_ext"},   ev_ext, 0);
        check({tag, "_brk"},   ev_break, 0);
        check({tag, "_err"},   err_count, 0);
        check({tag, "_ovf"},   ovf_seen, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fifo0.size() != 0 || exp0.size() != 0 || fifo1.size() != 0 || exp1.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (n >= 400) check({tag, "_timeout"}, 1, 0);
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        int p, c0, c1, n;
        logic held_ok;
        logic [7:0] pause_seq [8];
        logic [7:0] filt_seq [5];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        filt_seq  = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("rst");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // single make and its latency
        p = pops0;
        fifo0.push_back(8'h1C);
        exp0.push_back({8'h1C, 1'b0, 1'b0});
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("make_t3_valid", ev_valid, 0);
        @(negedge clk);
        check("make_t4_valid", ev_valid, 1);
        drain("make");
        check("make_pops", pops0 - p, 1);

        // extended release held by backpressure, next byte must stay in FIFO
        ev_ready = 1'b0;
        fifo0.push_back(8'hE0); fifo0.push_back(8'hF0);
        fifo0.push_back(8'h75); fifo0.push_back(8'h34);
        exp0.push_back({8'h75, 1'b1, 1'b1});
        exp0.push_back({8'h34, 1'b0, 1'b0});
        n = 0;
        while (!ev_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_wait_timeout", (n >= 100), 0);
        p = pops0;
        held_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(ev_valid && ev_code == 8'h75 && ev_ext && ev_break)) held_ok = 1'b0;
        end
        check("bp_stable", held_ok, 1);
        check("bp_no_pop", pops0 - p, 0);
        check("bp_fifo_kept", fifo0.size(), 1);
        @(posedge clk);
        #1 ev_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_released", ev_valid, 0);
        drain("bp");

        // typematic filter on (dut0) and off (dut1)
        c0 = ev_cnt0;
        c1 = ev_cnt1;
        foreach (filt_seq[i]) begin
            fifo0.push_back(filt_seq[i]);
            fifo1.push_back(filt_seq[i]);
        end
        exp0.push_back({8'h1C, 1'b0, 1'b0});
        exp0.push_back({8'h1C, 1'b0, 1'b1});
        repeat (3) exp1.push_back({8'h1C, 1'b0, 1'b0});
        exp1.push_back({8'h1C, 1'b0, 1'b1});
        drain("filt");
        check("filt_on_count", ev_cnt0 - c0, 2);
        check("filt_off_count", ev_cnt1 - c1, 4);

        // Pause collapses to a single event
        c0 = ev_cnt0;
        p = pops0;
        foreach (pause_seq[i]) fifo0.push_back(pause_seq[i]);
        exp0.push_back({8'h77, 1'b1, 1'b0});
        drain("pause");
        check("pause_count", ev_cnt0 - c0, 1);
        check("pause_pops", pops0 - p, 8);

        // line errors, self-test and overflow
        fifo0.push_back(8'hFF); fifo0.push_back(8'h00);
        fifo0.push_back(8'hAA); fifo0.push_back(8'h2B);
        exp0.push_back({8'h2B, 1'b0, 1'b0});
        drain("err");
        check("err_count", err_count, 2);
        check("ovf_before", ovf_seen, 0);
        @(posedge clk);
        #1 kbd_overflow = 1'b1;
        @(posedge clk);
        #1 kbd_overflow = 1'b0;
        check("ovf_set", ovf_seen, 1);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_sticky", ovf_seen, 1);

        // reset mid-prefix, overflow asserted with reset
        fifo0.push_back(8'hE0); fifo0.push_back(8'hF0);
        drain("pre_rst");
        reset = 1'b1;
        kbd_overflow = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outs("rst_mid");
        reset = 1'b0;
        kbd_overflow = 1'b0;
        fifo0.push_back(8'h1C);
        exp0.push_back({8'h1C, 1'b0, 1'b0});
        drain("post_rst");
        check("post_rst_ovf", ovf_seen, 0);

        check("no_double_pop", dbl_low, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
